// File: rtl/bru_pkg.sv
// Shared definitions for the branch resolve unit: RISC-V funct3 encodings and
// the layout of one stored result entry.
package bru_pkg;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_SLT  = 3'b010;
   localparam logic [2:0] F3_SLTU = 3'b011;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   // The SLT/SLTU result is a single bit; the upper result bits are always zero.
   localparam int SLT_BIT_W = 1;
   localparam int FLAG_W    = 2 + SLT_BIT_W;

   typedef struct packed {
      logic taken;
      logic illegal;
      logic slt_bit;
   } bru_flags_t;

endpackage

// File: rtl/bru_cmp_core.sv
// Combinational operand comparator: equality, unsigned less-than and signed
// less-than for DATA_W-bit operands.
module bru_cmp_core #(
   parameter int DATA_W = 32
) (
   input  logic [DATA_W-1:0] op_a_i,
   input  logic [DATA_W-1:0] op_b_i,
   output logic              eq_o,
   output logic              lt_o,
   output logic              ltu_o
);

   logic low_ltu;

   assign eq_o    = (op_a_i == op_b_i);
   assign ltu_o   = (op_a_i < op_b_i);
   assign low_ltu = (op_a_i[DATA_W-2:0] < op_b_i[DATA_W-2:0]);

   // Differing signs: a is smaller exactly when a is the negative one.
   assign lt_o = (op_a_i[DATA_W-1] != op_b_i[DATA_W-1]) ? op_a_i[DATA_W-1] : low_ltu;

endmodule

// File: rtl/branch_resolve_unit.sv
// Registered branch / SLT resolution stage with a 2-entry skid buffer.
// Define BRU_TARGET_EN to add branch target computation and misalign flagging.
module branch_resolve_unit
   import bru_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              flush_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [DATA_W-1:0] op_a_i,
   input  logic [DATA_W-1:0] op_b_i,
   input  logic [2:0]        funct3_i,
   input  logic              is_branch_i,
`ifdef BRU_TARGET_EN
   input  logic [DATA_W-1:0] pc_i,
   input  logic [DATA_W-1:0] imm_i,
   output logic [DATA_W-1:0] target_o,
   output logic              misalign_o,
`endif
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic              taken_o,
   output logic [DATA_W-1:0] slt_res_o,
   output logic              illegal_o
);

   logic       eq, lt, ltu;
   logic       accept;
   bru_flags_t in_flags;

   logic       m_valid_q, m_valid_d, s_valid_q, s_valid_d;
   bru_flags_t m_flags_q, m_flags_d, s_flags_q, s_flags_d;
`ifdef BRU_TARGET_EN
   logic [DATA_W-1:0] in_target;
   logic [DATA_W-1:0] m_target_q, m_target_d, s_target_q, s_target_d;
   assign in_target = pc_i + imm_i;
`endif

   bru_cmp_core #(.DATA_W(DATA_W)) u_cmp (
      .op_a_i (op_a_i),
      .op_b_i (op_b_i),
      .eq_o   (eq),
      .lt_o   (lt),
      .ltu_o  (ltu)
   );

   always_comb begin
      // NOTE: every signal assigned here gets a default first so no path infers a latch.
      in_flags = '0;
      if (is_branch_i) begin
         unique case (funct3_i)
            F3_BEQ:  in_flags.taken = eq;
            F3_BNE:  in_flags.taken = !eq;
            F3_BLT:  in_flags.taken = lt;
            F3_BGE:  in_flags.taken = !lt;
            F3_BLTU: in_flags.taken = ltu;
            F3_BGEU: in_flags.taken = !ltu;
            default: in_flags.illegal = 1'b1;
         endcase
      end else begin
         unique case (funct3_i)
            F3_SLT:  in_flags.slt_bit = lt;
            F3_SLTU: in_flags.slt_bit = ltu;
            default: in_flags.illegal = 1'b1;
         endcase
      end
   end

   // Depends only on stored state and flush, never on out_ready_i.
   assign in_ready_o = !s_valid_q && !flush_i;
   assign accept     = in_valid_i && in_ready_o;

   always_comb begin
      m_valid_d = m_valid_q;
      s_valid_d = s_valid_q;
      m_flags_d = m_flags_q;
      s_flags_d = s_flags_q;
`ifdef BRU_TARGET_EN
      m_target_d = m_target_q;
      s_target_d = s_target_q;
`endif
      if (flush_i) begin
         m_valid_d = 1'b0;
         s_valid_d = 1'b0;
      end else if (!m_valid_q || out_ready_i) begin
         // M is free or draining: refill from S first to keep FIFO order.
         if (s_valid_q) begin
            m_valid_d = 1'b1;
            m_flags_d = s_flags_q;
            s_valid_d = 1'b0;
`ifdef BRU_TARGET_EN
            m_target_d = s_target_q;
`endif
         end else begin
            m_valid_d = accept;
            if (accept) begin
               m_flags_d = in_flags;
`ifdef BRU_TARGET_EN
               m_target_d = in_target;
`endif
            end
         end
      end else if (accept) begin
         s_valid_d = 1'b1;
         s_flags_d = in_flags;
`ifdef BRU_TARGET_EN
         s_target_d = in_target;
`endif
      end
   end

   // NOTE: payload registers are reset too, since outputs must read zero out of reset.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         m_valid_q <= 1'b0;
         s_valid_q <= 1'b0;
         m_flags_q <= '0;
         s_flags_q <= '0;
`ifdef BRU_TARGET_EN
         m_target_q <= '0;
         s_target_q <= '0;
`endif
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         m_valid_q <= m_valid_d;
         s_valid_q <= s_valid_d;
         m_flags_q <= m_flags_d;
         s_flags_q <= s_flags_d;
`ifdef BRU_TARGET_EN
         m_target_q <= m_target_d;
         s_target_q <= s_target_d;
`endif
      end
   end

   assign out_valid_o = m_valid_q;
   assign taken_o     = m_flags_q.taken;
   assign illegal_o   = m_flags_q.illegal;
   assign slt_res_o   = {{(DATA_W-1){1'b0}}, m_flags_q.slt_bit};
`ifdef BRU_TARGET_EN
   assign target_o    = m_target_q;
   assign misalign_o  = m_flags_q.taken && (m_target_q[1:0] != 2'b00);
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed self-checking bench for branch_resolve_unit (default DATA_W = 32).
module tb_branch_resolve_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] op_a = '0;
   logic [31:0] op_b = '0;
   logic [2:0]  funct3 = '0;
   logic        is_branch = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic        taken;
   logic [31:0] slt_res;
   logic        illegal;
`ifdef BRU_TARGET_EN
   logic [31:0] pc = '0;
   logic [31:0] imm = '0;
   logic [31:0] target;
   logic        misalign;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   branch_resolve_unit #(.DATA_W(32)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .flush_i     (flush),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .op_a_i      (op_a),
      .op_b_i      (op_b),
      .funct3_i    (funct3),
      .is_branch_i (is_branch),
`ifdef BRU_TARGET_EN
      .pc_i        (pc),
      .imm_i       (imm),
      .target_o    (target),
      .misalign_o  (misalign),
`endif
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .taken_o     (taken),
      .slt_res_o   (slt_res),
      .illegal_o   (illegal)
   );

   task automatic set_op(input logic br, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      is_branch = br;
      funct3    = f3;
      op_a      = a;
      op_b      = b;
      in_valid  = 1'b1;
   endtask

   task automatic test_reset();
      #12;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
      checks++; if (taken !== 1'b0) begin errors++; $display("FAIL reset_taken: got %b expected 0", taken); end
      checks++; if (slt_res !== 32'h0) begin errors++; $display("FAIL reset_slt_res: got %h expected 0", slt_res); end
      checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL reset_illegal: got %b expected 0", illegal); end
`ifdef BRU_TARGET_EN
      checks++; if (target !== 32'h0) begin errors++; $display("FAIL reset_target: got %h expected 0", target); end
      checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL reset_misalign: got %b expected 0", misalign); end
`endif
      rst = 1'b0;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
   endtask

   // One transaction with out_ready held high: result one cycle after accept, then drained.
   task automatic run_single(input string name, input logic br, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] b,
                             input logic exp_taken, input logic [31:0] exp_slt, input logic exp_illegal);
      @(posedge clk); #1;
      out_ready = 1'b1;
      set_op(br, f3, a, b);
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL %s_in_ready: got %b expected 1", name, in_ready); end
      @(posedge clk); #1;
      in_valid = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL %s_out_valid: got %b expected 1", name, out_valid); end
      checks++; if (taken !== exp_taken) begin errors++; $display("FAIL %s_taken: got %b expected %b", name, taken, exp_taken); end
      checks++; if (slt_res !== exp_slt) begin errors++; $display("FAIL %s_slt_res: got %h expected %h", name, slt_res, exp_slt); end
      checks++; if (illegal !== exp_illegal) begin errors++; $display("FAIL %s_illegal: got %b expected %b", name, illegal, exp_illegal); end
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL %s_drained: got %b expected 0", name, out_valid); end
   endtask

   task automatic test_branch();
      run_single("blt",  1'b1, 3'b100, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 32'h0, 1'b0);
      run_single("bltu", 1'b1, 3'b110, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 32'h0, 1'b0);
      run_single("beq",  1'b1, 3'b000, 32'h0000_1234, 32'h0000_1234, 1'b1, 32'h0, 1'b0);
      run_single("bge",  1'b1, 3'b101, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b0, 32'h0, 1'b0);
      run_single("bgeu", 1'b1, 3'b111, 32'hFFFF_FFFE, 32'h0000_0001, 1'b1, 32'h0, 1'b0);
   endtask

   task automatic test_slt();
      run_single("slt",  1'b0, 3'b010, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h1, 1'b0);
      run_single("sltu", 1'b0, 3'b011, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0, 1'b0);
   endtask

   task automatic test_illegal();
      run_single("ill_br",  1'b1, 3'b010, 32'h5, 32'h5, 1'b0, 32'h0, 1'b1);
      run_single("ill_alu", 1'b0, 3'b000, 32'h1, 32'h2, 1'b0, 32'h0, 1'b1);
   endtask

   // Eight ops back to back with out_ready low in cycles 3..6; expected {taken,slt,illegal} per op.
   task automatic test_back_to_back();
      logic        br_t [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
      logic [2:0]  f3_t [8] = '{3'b000, 3'b010, 3'b001, 3'b011, 3'b101, 3'b011, 3'b110, 3'b000};
      logic [31:0] a_t  [8] = '{32'h5, 32'hFFFF_FFFF, 32'h5, 32'h0, 32'h3, 32'h1, 32'hFFFF_FFFF, 32'h0};
      logic [31:0] b_t  [8] = '{32'h5, 32'h1, 32'h5, 32'h0, 32'h2, 32'h2, 32'h0, 32'h0};
      logic [2:0]  exp_t[8] = '{3'b100, 3'b010, 3'b000, 3'b001, 3'b100, 3'b010, 3'b000, 3'b001};
      int in_idx = 0;
      int out_idx = 0;
      logic saw_not_ready = 1'b0;
      logic acc, take;
      for (int cyc = 0; cyc < 40 && out_idx < 8; cyc++) begin
         @(posedge clk); #1;
         out_ready = !(cyc >= 3 && cyc <= 6);
         if (in_idx < 8) set_op(br_t[in_idx], f3_t[in_idx], a_t[in_idx], b_t[in_idx]);
         else in_valid = 1'b0;
         #1;
         acc  = in_valid && in_ready;
         take = out_valid && out_ready;
         if (in_valid && !in_ready) saw_not_ready = 1'b1;
         if (take) begin
            checks++;
            if ({taken, slt_res[0], illegal} !== exp_t[out_idx]) begin
               errors++;
               $display("FAIL b2b_result%0d: got %b expected %b", out_idx, {taken, slt_res[0], illegal}, exp_t[out_idx]);
            end
            out_idx++;
         end
         if (acc) in_idx++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      checks++; if (out_idx !== 8) begin errors++; $display("FAIL b2b_count: got %0d expected 8", out_idx); end
      checks++; if (saw_not_ready !== 1'b1) begin errors++; $display("FAIL b2b_backpressure: got %b expected 1", saw_not_ready); end
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty: got %b expected 0", out_valid); end
   endtask

   task automatic test_flush();
      @(posedge clk); #1;
      out_ready = 1'b0;
      set_op(1'b1, 3'b000, 32'h7, 32'h7);
      @(posedge clk); #1;
      set_op(1'b0, 3'b010, 32'hFFFF_FFFF, 32'h1);
      @(posedge clk); #1;
      set_op(1'b1, 3'b000, 32'h9, 32'h9);
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_skid_full: got %b expected 0", in_ready); end
      flush = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready: got %b expected 0", in_ready); end
      @(posedge clk); #1;
      flush = 1'b0;
      in_valid = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid: got %b expected 0", out_valid); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_ready_after: got %b expected 1", in_ready); end
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_no_accept: got %b expected 0", out_valid); end
      out_ready = 1'b1;
   endtask

   task automatic test_async_reset();
      @(posedge clk); #1;
      set_op(1'b1, 3'b000, 32'h3, 32'h3);
      @(posedge clk); #1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL arst_pre_valid: got %b expected 1", out_valid); end
      #1;
      rst = 1'b1;
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL arst_out_valid: got %b expected 0", out_valid); end
      checks++; if (taken !== 1'b0) begin errors++; $display("FAIL arst_taken: got %b expected 0", taken); end
      @(posedge clk); #1;
      rst = 1'b0;
      out_ready = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL arst_in_ready: got %b expected 1", in_ready); end
   endtask

`ifdef BRU_TARGET_EN
   task automatic test_target();
      @(posedge clk); #1;
      pc  = 32'h100;
      imm = 32'h2;
      set_op(1'b1, 3'b000, 32'h4, 32'h4);
      @(posedge clk); #1;
      set_op(1'b1, 3'b001, 32'h4, 32'h4);
      #1;
      checks++; if (target !== 32'h102) begin errors++; $display("FAIL beq_target: got %h expected 102", target); end
      checks++; if (misalign !== 1'b1) begin errors++; $display("FAIL beq_misalign: got %b expected 1", misalign); end
      @(posedge clk); #1;
      in_valid = 1'b0;
      #1;
      checks++; if (taken !== 1'b0) begin errors++; $display("FAIL bne_taken: got %b expected 0", taken); end
      checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL bne_misalign: got %b expected 0", misalign); end
   endtask
`endif

   initial begin
      test_reset();
      test_branch();
      test_slt();
      test_illegal();
      test_back_to_back();
      test_flush();
      run_single("post_flush", 1'b1, 3'b001, 32'h1, 32'h2, 1'b1, 32'h0, 1'b0);
      test_async_reset();
`ifdef BRU_TARGET_EN
      test_target();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Registered branch/set-less-than resolution stage sitting directly downstream of the ALU operand comparators in the jedro-1 execute path. Accepts two operands plus funct3 over a valid/ready handshake, resolves BEQ/BNE/BLT/BGE/BLTU/BGEU taken and SLT/SLTU results, and presents them one cycle later to the writeback/fetch-redirect logic. A 2-entry skid buffer keeps full throughput under downstream backpressure.

## Interface
- DATA_W, 32, operand/result width (≥2)
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous, active-high reset
- flush_i  in  1  kill all in-flight entries (pipeline flush)
- in_valid_i  in  1  input transaction valid
- in_ready_o  out  1  stage can accept input
- op_a_i  in  DATA_W  rs1 operand
- op_b_i  in  DATA_W  rs2 operand
- funct3_i  in  3  RISC-V funct3
- is_branch_i  in  1  1 = branch op, 0 = SLT/SLTU op
- pc_i  in  DATA_W  branch PC (only with BRU_TARGET_EN)
- imm_i  in  DATA_W  sign-extended B-immediate (only with BRU_TARGET_EN)
- out_valid_o  out  1  result valid
- out_ready_i  in  1  consumer accepts result
- taken_o  out  1  branch taken
- slt_res_o  out  DATA_W  SLT/SLTU result, {DATA_W-1 zeros, lt}
- illegal_o  out  1  unsupported funct3/is_branch combination
- target_o  out  DATA_W  pc_i+imm_i (only with BRU_TARGET_EN)
- misalign_o  out  1  taken && target_o[1:0]!=0 (only with BRU_TARGET_EN)

## Operation
- Compare core: eq = (a==b); ltu = unsigned a<b; lt = signed: sign bits differ → lt = a[MSB]; equal signs → unsigned compare of low DATA_W-1 bits.
- Branch (is_branch_i=1): 000 eq, 001 !eq, 100 lt, 101 !lt, 110 ltu, 111 !ltu; 010/011 → taken 0, illegal 1.
- Non-branch (is_branch_i=0): 010 slt_res=lt, 011 slt_res=ltu; other funct3 → slt_res 0, illegal 1. taken_o always 0 for non-branch.
- slt_res_o is 0 for branch ops.
- Storage: main register M and skid register S, each with valid bit. Results computed combinationally at input and registered on accept.
- Accept = in_valid_i && in_ready_o. in_ready_o = !S.valid && !flush_i.
- Output driven from M. On out_valid_o && out_ready_i: M ← S if S.valid (S cleared), else M ← accepted input or invalid.
- Accept while M valid and not draining → entry goes to S.
- Order strictly FIFO; no entry dropped or duplicated except by flush.

## Timing
- Reset: M.valid=S.valid=0; out_valid_o=0, in_ready_o=1 (once rst_i low and flush_i low), taken_o=0, slt_res_o=0, illegal_o=0, target_o=0, misalign_o=0.
- Latency: accept in cycle N → out_valid_o in N+1.
- Throughput: 1/cycle while out_ready_i held high.
- out_ready_i low with M valid: M payload and out_valid_o held stable; one further accept lands in S, then in_ready_o drops the following cycle.
- in_ready_o is registered-state derived except the flush_i term; no combinational path from out_ready_i to in_ready_o.
- flush_i: both valid bits cleared at the edge; same-cycle input not accepted; same-cycle output handshake is ignored by consumer contract. out_valid_o=0 next cycle.
- Reset asserted mid-operation: all state cleared asynchronously, outputs at reset values immediately.
- Payload registers of invalid entries are don't-care except at reset.

## Configuration
- BRU_TARGET_EN defined: pc_i, imm_i, target_o, misalign_o exist; target computed as pc_i+imm_i modulo 2^DATA_W, stored with the entry; misalign_o = taken && target[1:0]!=0.
- Undefined: those ports and their storage absent; all other behaviour identical.

## Structure
- Shared package bru_pkg: funct3 constants (F3_BEQ, F3_BNE, F3_SLT, F3_SLTU, F3_BLT, F3_BGE, F3_BLTU, F3_BGEU) and result entry field widths.
- One sub-module: bru_cmp_core (combinational eq/lt/ltu for DATA_W); skid buffer and decode live in top level.

## Test plan
- BLT a=0x80000000 b=0x7FFFFFFF → taken_o=1 one cycle after accept; BLTU same operands → taken_o=0.
- SLT a=0xFFFFFFFF b=0x00000001 → slt_res_o=0x00000001; SLTU same → 0x00000000; BEQ a=b=0x1234 → taken 1.
- Back-to-back 8 ops, out_ready_i low cycles 3–6 → in_ready_o low after skid fills, all 8 results out in order, none lost.
- funct3=010 with is_branch_i=1 → illegal_o=1, taken_o=0.
- flush_i with M and S valid → out_valid_o=0 next cycle, simultaneous input not accepted.
- BRU_TARGET_EN: pc=0x100, imm=0x2, BEQ taken → target_o=0x102, misalign_o=1; BNE not taken → misalign_o=0.
